// File: rtl/bht_ctrl.sv
// bht_ctrl: 2-bit branch history table with queued updates and starvation-bounded lookup arbitration
module bht_ctrl #(
  parameter int IDX_W      = 4,
  parameter int Q_DEPTH    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [IDX_W-1:0]         req_idx,
  output logic                     req_ready,
  output logic                     pred_valid,
  output logic                     prediction,
  input  logic                     res_valid,
  input  logic [IDX_W-1:0]         res_idx,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic [$clog2(Q_DEPTH):0] q_count
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN} op_t;
  op_t              op;
  logic [1:0]       tbl [2**IDX_W];
  logic [IDX_W-1:0] q_idx [Q_DEPTH];
  logic             q_tk [Q_DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [SW-1:0]    starve_cnt;
  logic             full, empty, force_drain, push, drain, d_tk;
  logic [IDX_W-1:0] d_idx;
  logic [1:0]       cur, nxt;
  // arbitration: forced drains (full or starved) pre-empt lookups; head-entry counter update
  always_comb begin
    full        = q_count == (PW+1)'(Q_DEPTH);
    empty       = q_count == '0;
    force_drain = full || (starve_cnt == SW'(STARVE_MAX) && !empty);
    req_ready   = !force_drain;
    res_ready   = !full;
    push        = res_valid && !full;
    op          = force_drain ? DRAIN : req_valid ? LOOKUP : !empty ? DRAIN : IDLE;
    drain       = op == DRAIN;
    d_idx       = q_idx[rp];
    d_tk        = q_tk[rp];
    cur         = tbl[d_idx];
    nxt         = d_tk ? (cur == 2'd3 ? cur : cur + 2'd1) : (cur == 2'd0 ? cur : cur - 2'd1);
  end
  // counter table: reset to strongly taken, written only by drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= 2'd3;
    else if (drain) tbl[d_idx] <= nxt;
  end
  // queue payload storage needs no reset; occupancy alone says what is live
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wp] <= res_idx;
      q_tk[wp]  <= res_taken;
    end
  end
  // queue pointers and occupancy; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      q_count <= '0;
    end else begin
      wp      <= push ? wp + 1'b1 : wp;
      rp      <= drain ? rp + 1'b1 : rp;
      q_count <= q_count + (PW+1)'(push) - (PW+1)'(drain);
    end
  end
  // count lookups granted while updates wait; any drain or an empty queue clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt <= '0;
    else if (drain || empty) starve_cnt <= '0;
    else if (op == LOOKUP && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  end
  // registered prediction one cycle after a lookup grant; value holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid <= 1'b0;
      prediction <= 1'b0;
    end else begin
      pred_valid <= op == LOOKUP;
      prediction <= op == LOOKUP ? tbl[req_idx][1] : prediction;
    end
  end
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: scoreboard bench for bht_ctrl with directed lookup/update sequences
module tb_bht_ctrl;
  logic       clk, rst, req_valid, req_ready, pred_valid, prediction;
  logic       res_valid, res_taken, res_ready;
  logic [3:0] req_idx, res_idx;
  logic [2:0] q_count;
  logic       cur_exp;
  logic       sb[$];
  int         total, passed;

  bht_ctrl #(.IDX_W(4), .Q_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .pred_valid(pred_valid), .prediction(prediction), .res_valid(res_valid), .res_idx(res_idx),
    .res_taken(res_taken), .res_ready(res_ready), .q_count(q_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // monitor pops the oldest expectation per prediction, then records any grant being offered
  always @(negedge clk) begin
    if (!rst && pred_valid) begin
      if (sb.size() == 0) check("unexpected_pred_valid", 1, 0);
      else check("prediction", int'(prediction), int'(sb.pop_front()));
    end
    if (!rst && req_valid && req_ready) sb.push_back(cur_exp);
  end

  task automatic lookup(input logic [3:0] idx, input logic exp);
    int n = 0;
    req_idx = idx; cur_exp = exp; req_valid = 1;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) check("lookup_grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic push_upd(input logic [3:0] idx, input logic tk);
    int n = 0;
    res_idx = idx; res_taken = tk; res_valid = 1;
    @(negedge clk);
    while (!res_ready && n < 50) begin @(negedge clk); n++; end
    if (!res_ready) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    res_valid = 0;
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge clk);
    while (q_count != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain_to_empty", int'(q_count), 0);
    @(posedge clk); #1;
  endtask

  task automatic count_grants(input string name);
    int n = 0;
    do begin @(negedge clk); if (req_ready) n++; end while (req_ready && n < 30);
    check(name, n, 8);
    check({name, "_qcount_before_drain"}, int'(q_count), 1);
    @(negedge clk);
    check({name, "_qcount_after_drain"}, int'(q_count), 0);
    check({name, "_ready_after_drain"}, int'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; passed = 0;
    rst = 1; req_valid = 0; req_idx = 0; res_valid = 0; res_idx = 0; res_taken = 0; cur_exp = 0;
    #2;
    check("rst_q_count", int'(q_count), 0);
    check("rst_pred_valid", int'(pred_valid), 0);
    check("rst_prediction", int'(prediction), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_req_ready", int'(req_ready), 1);
    check("post_rst_res_ready", int'(res_ready), 1);
    @(posedge clk); #1;
    // reset state predicts taken
    lookup(5, 1);
    check("lookup_q_count", int'(q_count), 0);
    // four not-taken saturate at SNT, then climb back
    repeat (4) push_upd(2, 0);
    wait_empty();
    lookup(2, 0);
    push_upd(2, 1); wait_empty(); lookup(2, 0);
    push_upd(2, 1); wait_empty(); lookup(2, 1);
    push_upd(2, 0); push_upd(2, 0); wait_empty(); lookup(2, 0);
    // fill the queue under continuous lookups
    req_idx = 5; cur_exp = 1; req_valid = 1;
    repeat (4) push_upd(7, 1);
    @(negedge clk);
    check("full_q_count", int'(q_count), 4);
    check("full_res_ready", int'(res_ready), 0);
    check("full_req_ready", int'(req_ready), 0);
    @(negedge clk);
    check("after_full_q_count", int'(q_count), 3);
    check("after_full_res_ready", int'(res_ready), 1);
    @(posedge clk); #1 req_valid = 0;
    wait_empty();
    // starvation bound: eight grants then one forced drain, twice
    req_idx = 5; cur_exp = 1; req_valid = 1;
    push_upd(9, 1);
    count_grants("starve_grants_1");
    @(posedge clk); #1;
    push_upd(9, 1);
    count_grants("starve_grants_2");
    @(posedge clk); #1 req_valid = 0;
    wait_empty();
    // simultaneous push and drain at two entries; order across wrap
    req_idx = 5; cur_exp = 1; req_valid = 1;
    push_upd(11, 0); push_upd(11, 0);
    req_valid = 0;
    push_upd(11, 0);
    @(negedge clk);
    check("push_drain_q_count", int'(q_count), 2);
    push_upd(11, 0); push_upd(11, 1); push_upd(11, 1);
    wait_empty();
    lookup(11, 1);
    // asynchronous reset with three queued updates and a lookup in flight
    req_idx = 5; cur_exp = 1; req_valid = 1;
    repeat (3) push_upd(2, 1);
    #2 rst = 1; sb.delete(); req_valid = 0;
    #1;
    check("async_rst_q_count", int'(q_count), 0);
    check("async_rst_pred_valid", int'(pred_valid), 0);
    check("async_rst_prediction", int'(prediction), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst2_req_ready", int'(req_ready), 1);
    check("rst2_res_ready", int'(res_ready), 1);
    check("rst2_no_pred", int'(pred_valid), 0);
    @(posedge clk); #1;
    lookup(2, 1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
